d_stall_ctrl: RTL and testbench
===============================

// Module: d_stall_ctrl
// PURPOSE
//  Decode-stage pipeline scheduler for the 5-stage MIPS core. Detects RAW hazards on the
//  two RF read ports (rs/rt) against E/M writers using Tuse/Tnew, and sequences the
//  multi-cycle mult/div unit (MDU) via an internal busy counter. Drives one stall that
//  freezes PC and IF/ID and inserts a bubble into ID/EX. Keeps a stall-cycle perf counter.
// PARAMETERS
//  MULT_CYC  5   busy cycles after a mult/multu leaves E
//  DIV_CYC   10  busy cycles after a div/divu leaves E
//  CNT_W     32  width of stall_cnt
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high; clears all state
//  rs_D       in   5      rs field of instruction in D
//  rt_D       in   5      rt field of instruction in D
//  tuse_rs    in   2      cycles until rs needed (0..2; 3 = not used)
//  tuse_rt    in   2      cycles until rt needed (0..2; 3 = not used)
//  md_D       in   1      D instr touches MDU/HI/LO (mult,div,mfhi,mflo,mthi,mtlo)
//  wa_E       in   5      dest reg of instruction in E (0 = none)
//  tnew_E     in   2      cycles until E result ready (0..2)
//  wa_M       in   5      dest reg of instruction in M (0 = none)
//  tnew_M     in   2      cycles until M result ready (0..1)
//  start_E    in   1      mult/div in E this cycle
//  is_div_E   in   1      1 = start_E is div/divu, 0 = mult/multu
//  exc_req    in   1      exception/interrupt taken at M; E and earlier flushed
//  stall      out  1      freeze PC + IF/ID, clear ID/EX
//  mdu_busy   out  1      MDU counting (counter != 0)
//  stall_cnt  out  CNT_W  cycles with stall=1 since reset
// BEHAVIOUR
//  - Reset: counter=0, stall_cnt=0 immediately (async). Outputs: mdu_busy=0.
//    stall=0 unless MDU or hazard terms assert from inputs.
//  - RAW: haz_rs = rs_D!=0 & tuse_rs<3 &
//    ((rs_D==wa_E & tuse_rs<tnew_E) | (rs_D==wa_M & tuse_rs<tnew_M)).
//    haz_rt identical on rt. Combinational, same cycle; reg 0 never stalls.
//  - MDU stall: stall_md = md_D & (mdu_busy | start_E).
//  - stall = haz_rs | haz_rt | stall_md, all same-cycle combinational, no latency.
//  - Counter (unsigned, 4 bits min., wide enough for max(MULT_CYC, DIV_CYC)):
//    - start_E & ~exc_req at edge t -> load DIV_CYC or MULT_CYC per is_div_E.
//    - Otherwise decrement while !=0; holds at 0, never wraps.
//    - mdu_busy=1 for exactly N cycles after the start edge.
//  - start_E while mdu_busy cannot occur (stall_md blocks it); if it does, reload wins.
//  - exc_req & start_E same cycle: E is flushed, no load. Countdown already running continues
//    (committed MDU op completes).
//  - stall_cnt += 1 each edge where stall=1; wraps modulo 2^CNT_W; not gated by exc_req.
//  - reset mid-countdown: counter->0, mdu_busy->0 asynchronously, no residual stall.
// STRUCTURE
//  - define.v gets: TUSE/TNEW encodings (incl. 2'd3 = unused), `mult_cyc / `div_cyc defaults.
//  - One sub-module mdu_busy_cnt (clk, reset, load, is_div, busy): counter load/decrement.
//  - Hazard compare and stall_cnt stay in the top module.
// TESTING
//  1 reset=1 mid-run -> stall_cnt=0, mdu_busy=0 same cycle, before next clk edge.
//  2 wa_E=5, tnew_E=2, rs_D=5, tuse_rs=0 -> stall=1. Then tuse_rs=1 -> stall=1;
//    tuse_rs=2 -> stall=0.
//  3 rs_D=0=wa_E, tnew_E=2, tuse_rs=0 -> stall=0. tuse_rt=3, rt_D=wa_M -> stall=0.
//  4 start_E=1, is_div_E=0 at edge t -> mdu_busy=1 for edges t+1..t+5, 0 after.
//    md_D=1 -> stall=1 in cycle t and all busy cycles, 0 in the first cycle mdu_busy=0.
//  5 div: start_E=1, is_div_E=1 -> busy 10 cycles. Same with exc_req=1 -> mdu_busy stays 0.
//  6 Hold stall=1 for 7 cycles -> stall_cnt increases by exactly 7.
//    Preset stall_cnt to 2^CNT_W-1 (force), then one stall cycle -> stall_cnt=0.

Source files
------------

// File: rtl/d_stall_ctrl_pkg.sv
// Shared definitions for the decode-stage stall controller.
//  - TUSE/TNEW encodings (TUSE_NONE marks an operand the D instruction never reads)
//  - default MDU latencies and perf-counter width
//  - stall_src_t: per-cause breakdown of the stall, exported for debug/observation
//  - mdu_cnt_bits(): width of the MDU busy counter (at least 4 bits)
package d_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NOW  = 2'd0;
  localparam logic [1:0] TUSE_ONE  = 2'd1;
  localparam logic [1:0] TUSE_TWO  = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_NOW  = 2'd0;
  localparam logic [1:0] TNEW_ONE  = 2'd1;
  localparam logic [1:0] TNEW_TWO  = 2'd2;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int CNT_W_DEF    = 32;

  typedef struct packed {
    logic haz_rs;
    logic haz_rt;
    logic stall_md;
  } stall_src_t;

  // Counter must hold the larger latency; never narrower than 4 bits.
  function automatic int mdu_cnt_bits(input int mult_cyc, input int div_cyc);
    int m;
    int w;
    m = (mult_cyc > div_cyc) ? mult_cyc : div_cyc;
    w = $clog2(m + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/d_stall_ctrl_if.sv
// Bundle of pipeline-side signals seen by the stall controller.
// All signals are level-qualified per cycle; there is no valid/ready handshake:
// the D/E/M fields describe whatever instructions occupy those stages this cycle,
// and stall is a same-cycle combinational answer to them.
//  master : pipeline side (drives D/E/M fields, receives stall info)
//  slave  : stall controller
//  stall_src is a debug view of which condition(s) raised stall.
interface d_stall_ctrl_if #(parameter int CNT_W = 32);
  import d_stall_ctrl_pkg::*;

  logic [4:0]       rs_D;
  logic [4:0]       rt_D;
  logic [1:0]       tuse_rs;
  logic [1:0]       tuse_rt;
  logic             md_D;
  logic [4:0]       wa_E;
  logic [1:0]       tnew_E;
  logic [4:0]       wa_M;
  logic [1:0]       tnew_M;
  logic             start_E;
  logic             is_div_E;
  logic             exc_req;
  logic             stall;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt;
  stall_src_t       stall_src;

  modport master (
    output rs_D, rt_D, tuse_rs, tuse_rt, md_D, wa_E, tnew_E, wa_M, tnew_M,
           start_E, is_div_E, exc_req,
    input  stall, mdu_busy, stall_cnt, stall_src
  );

  modport slave (
    input  rs_D, rt_D, tuse_rs, tuse_rt, md_D, wa_E, tnew_E, wa_M, tnew_M,
           start_E, is_div_E, exc_req,
    output stall, mdu_busy, stall_cnt, stall_src
  );

endinterface

// File: rtl/d_stall_ctrl_mdu_busy_cnt.sv
// MDU busy counter.
//  clk, reset : clock, async active-high reset (counter -> 0)
//  load       : a committed mult/div leaves E at this edge
//  is_div     : selects DIV_CYC (1) or MULT_CYC (0) on load
//  busy       : counter != 0
// A load always wins over the running countdown; otherwise the counter
// decrements to zero and holds there.
module mdu_busy_cnt
  import d_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam int W = mdu_cnt_bits(MULT_CYC, DIV_CYC);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = is_div ? W'(DIV_CYC) : W'(MULT_CYC);
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/d_stall_ctrl.sv
// Decode-stage stall controller for the 5-stage MIPS core.
//  clk, reset : clock, async active-high reset
//  bus        : d_stall_ctrl_if slave modport
//    in : rs_D/rt_D + tuse_rs/tuse_rt, md_D, wa_E/tnew_E, wa_M/tnew_M,
//         start_E, is_div_E, exc_req
//    out: stall (freeze PC/IF-ID, bubble ID/EX), mdu_busy, stall_cnt, stall_src
// A RAW hazard exists when an operand is needed sooner (tuse) than an E/M
// writer can forward it (tnew). MDU-touching instructions wait while the MDU
// is busy or one is just starting in E.
module d_stall_ctrl
  import d_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  d_stall_ctrl_if.slave  bus
);

  stall_src_t       src;
  logic             stall;
  logic             mdu_busy;
  logic             mdu_load;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // A flushed (exception) mult/div never started, so it must not load.
  assign mdu_load = bus.start_E & ~bus.exc_req;

  mdu_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_mdu_busy_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (mdu_load),
    .is_div (bus.is_div_E),
    .busy   (mdu_busy)
  );

  // $zero is never a real dependency; TUSE_NONE means the operand is unused.
  always_comb begin
    src = '0;
    src.haz_rs = (bus.rs_D != 5'd0) && (bus.tuse_rs != TUSE_NONE) &&
                 (((bus.rs_D == bus.wa_E) && (bus.tuse_rs < bus.tnew_E)) ||
                  ((bus.rs_D == bus.wa_M) && (bus.tuse_rs < bus.tnew_M)));
    src.haz_rt = (bus.rt_D != 5'd0) && (bus.tuse_rt != TUSE_NONE) &&
                 (((bus.rt_D == bus.wa_E) && (bus.tuse_rt < bus.tnew_E)) ||
                  ((bus.rt_D == bus.wa_M) && (bus.tuse_rt < bus.tnew_M)));
    src.stall_md = bus.md_D && (mdu_busy || bus.start_E);
  end

  assign stall = src.haz_rs | src.haz_rt | src.stall_md;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.mdu_busy  = mdu_busy;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.stall_src = src;

endmodule

// File: tb/tb_d_stall_ctrl.sv
// Bench for d_stall_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model (remaining-busy-cycles integer, stall tally).
// A second instance with a 3-bit stall counter shares the stimulus so the
// counter wrap can be observed without forcing.
module tb_d_stall_ctrl;
  import d_stall_ctrl_pkg::*;

  localparam int MULT_N  = 5;
  localparam int DIV_N   = 10;
  localparam int SMALL_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  d_stall_ctrl_if #(.CNT_W(32))      bus ();
  d_stall_ctrl_if #(.CNT_W(SMALL_W)) sbus ();

  d_stall_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  d_stall_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N), .CNT_W(SMALL_W)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus.slave)
  );

  assign sbus.rs_D     = bus.rs_D;
  assign sbus.rt_D     = bus.rt_D;
  assign sbus.tuse_rs  = bus.tuse_rs;
  assign sbus.tuse_rt  = bus.tuse_rt;
  assign sbus.md_D     = bus.md_D;
  assign sbus.wa_E     = bus.wa_E;
  assign sbus.tnew_E   = bus.tnew_E;
  assign sbus.wa_M     = bus.wa_M;
  assign sbus.tnew_M   = bus.tnew_M;
  assign sbus.start_E  = bus.start_E;
  assign sbus.is_div_E = bus.is_div_E;
  assign sbus.exc_req  = bus.exc_req;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int          rem_busy;   // MDU cycles still to run
  logic [31:0] cnt_m;      // stall cycles seen since reset
  logic [33:0] exp_q[$];   // {stall, busy, stall_cnt}

  // Operand hazard: a writer with matching register whose value arrives
  // later (tnew) than the operand is needed (tuse).
  function automatic bit ref_raw(input logic [4:0] r, input logic [1:0] tuse);
    logic [4:0] who[2];
    int         ready_in[2];
    who[0] = bus.wa_E; ready_in[0] = int'(bus.tnew_E);
    who[1] = bus.wa_M; ready_in[1] = int'(bus.tnew_M);
    if (r == 5'd0 || tuse == 2'd3) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (who[i] == r && int'(tuse) < ready_in[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit ref_stall();
    bit md_wait;
    md_wait = bus.md_D && (rem_busy > 0 || bus.start_E);
    return ref_raw(bus.rs_D, bus.tuse_rs) || ref_raw(bus.rt_D, bus.tuse_rt) || md_wait;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.rs_D = 5'd0; bus.rt_D = 5'd0;
    bus.tuse_rs = 2'd3; bus.tuse_rt = 2'd3;
    bus.md_D = 1'b0;
    bus.wa_E = 5'd0; bus.tnew_E = 2'd0;
    bus.wa_M = 5'd0; bus.tnew_M = 2'd0;
    bus.start_E = 1'b0; bus.is_div_E = 1'b0; bus.exc_req = 1'b0;
  endtask

  // Advance one clock edge and update the model; returns at edge + 1.
  task automatic tick();
    bit s;
    s = ref_stall();
    @(posedge clk);
    if (s) cnt_m = cnt_m + 32'd1;
    if (bus.start_E && !bus.exc_req) rem_busy = bus.is_div_E ? DIV_N : MULT_N;
    else if (rem_busy > 0) rem_busy = rem_busy - 1;
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rem_busy = 0;
    cnt_m = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    rem_busy = 0;
    cnt_m = '0;
    #1;
    checks++;
    if (bus.stall_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_cnt actual=%0d required=0", bus.stall_cnt);
    end
    checks++;
    if (bus.mdu_busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy actual=%b required=0", bus.mdu_busy);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall actual=%b required=0", bus.stall);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_raw();
    logic req[6];
    clear_inputs();
    req[0] = 1; req[1] = 1; req[2] = 0; req[3] = 0; req[4] = 0; req[5] = 1;
    bus.wa_E = 5'd5; bus.tnew_E = 2'd2; bus.rs_D = 5'd5; bus.tuse_rs = 2'd0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        1: bus.tuse_rs = 2'd1;
        2: bus.tuse_rs = 2'd2;
        3: begin bus.rs_D = 5'd0; bus.wa_E = 5'd0; bus.tuse_rs = 2'd0; end
        4: begin bus.rt_D = 5'd7; bus.wa_M = 5'd7; bus.tnew_M = 2'd1; bus.tuse_rt = 2'd3; end
        5: bus.tuse_rt = 2'd0;
        default: ;
      endcase
      #1;
      checks++;
      if (bus.stall !== req[i]) begin
        failures++; $display("FAIL raw_case%0d actual=%b required=%b", i, bus.stall, req[i]);
      end
    end
    checks++;
    if (bus.stall_src.haz_rt !== 1'b1) begin
      failures++; $display("FAIL raw_src_rt actual=%b required=1", bus.stall_src.haz_rt);
    end
    tick();
    checks++;
    if (bus.stall_cnt !== cnt_m) begin
      failures++; $display("FAIL raw_cnt actual=%0d required=%0d", bus.stall_cnt, cnt_m);
    end
  endtask

  task automatic test_mult();
    clear_inputs();
    bus.start_E = 1'b1; bus.is_div_E = 1'b0; bus.md_D = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.mdu_busy !== 1'b0) begin
      failures++; $display("FAIL mult_start stall=%b busy=%b required stall=1 busy=0", bus.stall, bus.mdu_busy);
    end
    tick();
    bus.start_E = 1'b0;
    for (int k = 1; k <= MULT_N; k++) begin
      #1;
      checks++;
      if (bus.mdu_busy !== 1'b1 || bus.stall !== 1'b1) begin
        failures++; $display("FAIL mult_busy%0d stall=%b busy=%b required 1/1", k, bus.stall, bus.mdu_busy);
      end
      tick();
    end
    checks++;
    if (bus.mdu_busy !== 1'b0 || bus.stall !== 1'b0) begin
      failures++; $display("FAIL mult_done stall=%b busy=%b required 0/0", bus.stall, bus.mdu_busy);
    end
    checks++;
    if (bus.stall_cnt !== cnt_m) begin
      failures++; $display("FAIL mult_cnt actual=%0d required=%0d", bus.stall_cnt, cnt_m);
    end
  endtask

  task automatic test_div();
    int busy_cycles;
    clear_inputs();
    bus.start_E = 1'b1; bus.is_div_E = 1'b1;
    tick();
    bus.start_E = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < DIV_N + 3; k++) begin
      if (bus.mdu_busy === 1'b1) busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != DIV_N) begin
      failures++; $display("FAIL div_len actual=%0d required=%0d", busy_cycles, DIV_N);
    end
    // flushed start: no load
    bus.start_E = 1'b1; bus.is_div_E = 1'b1; bus.exc_req = 1'b1;
    tick();
    bus.start_E = 1'b0; bus.exc_req = 1'b0;
    checks++;
    if (bus.mdu_busy !== 1'b0) begin
      failures++; $display("FAIL div_exc_busy actual=%b required=0", bus.mdu_busy);
    end
    // exception during a running countdown leaves it running
    bus.start_E = 1'b1; bus.is_div_E = 1'b0;
    tick();
    bus.start_E = 1'b0; bus.exc_req = 1'b1;
    tick();
    bus.exc_req = 1'b0;
    checks++;
    if (bus.mdu_busy !== 1'b1) begin
      failures++; $display("FAIL exc_keeps_busy actual=%b required=1", bus.mdu_busy);
    end
    // reload while busy restarts with the new latency
    bus.start_E = 1'b1; bus.is_div_E = 1'b1;
    tick();
    bus.start_E = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < DIV_N + 2; k++) begin
      if (bus.mdu_busy === 1'b1) busy_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != DIV_N) begin
      failures++; $display("FAIL reload_len actual=%0d required=%0d", busy_cycles, DIV_N);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus.start_E = 1'b1; bus.is_div_E = 1'b1;
    tick();
    bus.start_E = 1'b0; bus.md_D = 1'b1;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mdu_busy !== 1'b0 || bus.stall_cnt !== 32'd0 || sbus.stall_cnt !== 3'd0) begin
      failures++; $display("FAIL reset_mid busy=%b cnt=%0d scnt=%0d required 0/0/0",
                           bus.mdu_busy, bus.stall_cnt, sbus.stall_cnt);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL reset_mid_stall actual=%b required=0", bus.stall);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    rem_busy = 0;
    cnt_m = '0;
    bus.md_D = 1'b0;
  endtask

  task automatic test_stall_cnt();
    logic [31:0] base;
    clear_inputs();
    pulse_reset();
    base = bus.stall_cnt;
    bus.rs_D = 5'd3; bus.wa_E = 5'd3; bus.tnew_E = 2'd2; bus.tuse_rs = 2'd0;
    for (int k = 0; k < 7; k++) begin
      bus.exc_req = (k == 3);
      tick();
    end
    checks++;
    if (bus.stall_cnt !== 32'd7) begin
      failures++; $display("FAIL cnt_plus7 actual=%0d required=7 base=%0d", bus.stall_cnt, base);
    end
    checks++;
    if (sbus.stall_cnt !== 3'd7) begin
      failures++; $display("FAIL small_cnt_max actual=%0d required=7", sbus.stall_cnt);
    end
    tick();
    checks++;
    if (sbus.stall_cnt !== 3'd0) begin
      failures++; $display("FAIL small_cnt_wrap actual=%0d required=0", sbus.stall_cnt);
    end
    clear_inputs();
    tick();
    checks++;
    if (bus.stall_cnt !== 32'd8) begin
      failures++; $display("FAIL cnt_hold actual=%0d required=8", bus.stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [33:0] exp;
    logic [33:0] act;
    for (int n = 0; n < 400; n++) begin
      bus.rs_D     = 5'($urandom_range(0, 3));
      bus.rt_D     = 5'($urandom_range(0, 3));
      bus.tuse_rs  = 2'($urandom_range(0, 3));
      bus.tuse_rt  = 2'($urandom_range(0, 3));
      bus.wa_E     = 5'($urandom_range(0, 3));
      bus.tnew_E   = 2'($urandom_range(0, 2));
      bus.wa_M     = 5'($urandom_range(0, 3));
      bus.tnew_M   = 2'($urandom_range(0, 1));
      bus.md_D     = 1'($urandom_range(0, 1));
      bus.start_E  = ($urandom_range(0, 7) == 0);
      bus.is_div_E = 1'($urandom_range(0, 1));
      bus.exc_req  = ($urandom_range(0, 7) == 0);
      #1;
      exp_q.push_back({ref_stall(), (rem_busy > 0), cnt_m});
      act = {bus.stall, bus.mdu_busy, bus.stall_cnt};
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
        failures++; $display("FAIL rand%0d stall/busy/cnt actual=%b/%b/%0d required=%b/%b/%0d",
                             n, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
      end
      checks++;
      if (sbus.stall_cnt !== cnt_m[SMALL_W-1:0]) begin
        failures++; $display("FAIL rand%0d small_cnt actual=%0d required=%0d",
                             n, sbus.stall_cnt, cnt_m[SMALL_W-1:0]);
      end
      tick();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_raw();
    test_mult();
    test_div();
    test_reset_mid();
    test_stall_cnt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
